// File: rtl/exec_dispatch_pkg.sv
// exec_dispatch_pkg
// Shared defaults and record layouts for the execute-dispatch slice.
//   LEN_WORD_DEF / LEN_PREG_DEF : default result and physical-register widths
//   tag_t       : per-unit tag layout {rd_en, pa}
//   wb_entry_t  : write-back entry layout {pa, data}
//   pack_wb_entry / unpack_wb_pa / unpack_wb_data : entry helpers
// The typedefs describe the layout at the default widths; parametrised
// instances use plain vectors with the same bit order.
package exec_dispatch_pkg;

  localparam int LEN_WORD_DEF = 32;
  localparam int LEN_PREG_DEF = 6;

  typedef struct packed {
    logic                    rd_en;
    logic [LEN_PREG_DEF-1:0] pa;
  } tag_t;

  typedef struct packed {
    logic [LEN_PREG_DEF-1:0] pa;
    logic [LEN_WORD_DEF-1:0] data;
  } wb_entry_t;

  function automatic wb_entry_t pack_wb_entry(input logic [LEN_PREG_DEF-1:0] pa,
                                              input logic [LEN_WORD_DEF-1:0] data);
    wb_entry_t e;
    e.pa   = pa;
    e.data = data;
    return e;
  endfunction

  function automatic logic [LEN_PREG_DEF-1:0] unpack_wb_pa(input wb_entry_t e);
    return e.pa;
  endfunction

  function automatic logic [LEN_WORD_DEF-1:0] unpack_wb_data(input wb_entry_t e);
    return e.data;
  endfunction

endpackage

// File: rtl/exec_dispatch_wb_fifo.sv
// wb_fifo
// First-word-fall-through FIFO for write-back entries.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write request and data (ignored when full unless popping)
//   pop      : consume the head (ignored when empty)
//   dout     : head entry, valid while 'valid' is high
//   valid    : FIFO holds at least one entry
//   full     : FIFO holds DEPTH entries
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & valid;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/exec_dispatch.sv
// exec_dispatch
// Routes one decoded order per cycle to one of N_UNIT functional-unit slots,
// keeps one order in flight per unit, buffers each completed result in a
// per-unit hold register and drains those through an arbiter into a
// write-back FIFO towards register_manage.
//   clk, rst            : clock, synchronous active-high reset
//   order, unit_sel     : issue request and one-hot target unit
//   rd_en, pa_rd_in     : result-producing flag and destination register
//   accepted, busy_out  : order taken / selected unit not free
//   u_order, u_accepted : per-unit order strobe and accept
//   u_done, u_rd        : per-unit completion pulse and result (slot i at
//                         [i*LEN_WORD +: LEN_WORD])
//   wb_valid, wb_ready  : write-back handshake; wb_pa/wb_data show the head
//   err                 : sticky protocol error
// Handshake: an entry transfers on a cycle where wb_valid & wb_ready; the
// order transfers to unit i on a cycle where u_order[i] & u_accepted[i].
// Optional: EXEC_DISPATCH_RR_ARB_EN selects a round-robin drain arbiter
// instead of fixed lowest-index priority.
module exec_dispatch
  import exec_dispatch_pkg::*;
#(
  parameter int N_UNIT   = 4,
  parameter int LEN_WORD = LEN_WORD_DEF,
  parameter int LEN_PREG = LEN_PREG_DEF,
  parameter int WB_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       order,
  input  logic [N_UNIT-1:0]          unit_sel,
  input  logic                       rd_en,
  input  logic [LEN_PREG-1:0]        pa_rd_in,
  output logic                       accepted,
  output logic                       busy_out,
  output logic [N_UNIT-1:0]          u_order,
  input  logic [N_UNIT-1:0]          u_accepted,
  input  logic [N_UNIT-1:0]          u_done,
  input  logic [N_UNIT*LEN_WORD-1:0] u_rd,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [LEN_PREG-1:0]        wb_pa,
  output logic [LEN_WORD-1:0]        wb_data,
  output logic                       err
);

  localparam int IDX_W = (N_UNIT > 1) ? $clog2(N_UNIT) : 1;
  localparam int ENT_W = LEN_PREG + LEN_WORD;

  logic [N_UNIT-1:0]   inflight;
  logic [N_UNIT-1:0]   hold_valid;
  // Units whose order was in flight at reset; their late done is not an error.
  logic [N_UNIT-1:0]   stale;
  logic [N_UNIT-1:0]   free;
  logic [N_UNIT-1:0]   take;
  logic [N_UNIT-1:0]   done_ok;
  logic [N_UNIT-1:0]   done_bad;
  logic [N_UNIT-1:0]   grant;
  logic                grant_any;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    arb_start;
  logic                sel_onehot;
  logic                can_push;
  logic                fifo_full;
  logic                wb_pop;
  logic [ENT_W-1:0]    fifo_din;
  logic [ENT_W-1:0]    fifo_dout;

  // Tag layout {rd_en, pa}: bit LEN_PREG is rd_en.
  logic [LEN_PREG:0]   tag       [N_UNIT];
  logic [LEN_PREG-1:0] hold_pa   [N_UNIT];
  logic [LEN_WORD-1:0] hold_data [N_UNIT];

  assign free       = ~inflight & ~hold_valid;
  assign sel_onehot = (unit_sel != '0) && ((unit_sel & (unit_sel - N_UNIT'(1))) == '0);
  assign u_order    = (order && sel_onehot) ? (unit_sel & free) : '0;
  assign take       = u_order & u_accepted;
  assign accepted   = |take;
  assign busy_out   = order & (|(unit_sel & ~free));
  assign done_ok    = u_done & inflight;
  assign done_bad   = u_done & ~inflight & ~stale;

  assign wb_pop     = wb_valid & wb_ready;
  assign can_push   = ~fifo_full | wb_pop;

`ifdef EXEC_DISPATCH_RR_ARB_EN
  logic [IDX_W-1:0] rr_ptr;
  assign arb_start = rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_idx == IDX_W'(N_UNIT-1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end
`else
  assign arb_start = '0;
`endif

  // Scan hold registers starting at arb_start; the first valid one wins.
  always_comb begin : arb
    int idx;
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_UNIT; k++) begin
      idx = int'(arb_start) + k;
      if (idx >= N_UNIT) idx = idx - N_UNIT;
      if (!grant_any && can_push && hold_valid[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

  assign fifo_din = {hold_pa[grant_idx], hold_data[grant_idx]};

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= '0;
      hold_valid <= '0;
      stale      <= inflight;
      err        <= 1'b0;
      for (int i = 0; i < N_UNIT; i++) begin
        tag[i]       <= '0;
        hold_pa[i]   <= '0;
        hold_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_UNIT; i++) begin
        if (u_done[i] && stale[i] && !inflight[i]) stale[i] <= 1'b0;
        if (take[i]) begin
          inflight[i] <= 1'b1;
          tag[i]      <= {rd_en, pa_rd_in};
          stale[i]    <= 1'b0;
        end else if (done_ok[i]) begin
          inflight[i] <= 1'b0;
          if (tag[i][LEN_PREG]) begin
            hold_valid[i] <= 1'b1;
            hold_pa[i]    <= tag[i][LEN_PREG-1:0];
            hold_data[i]  <= u_rd[i*LEN_WORD +: LEN_WORD];
          end
        end
        // A granted unit has no order in flight, so this never races the set above.
        if (grant[i]) hold_valid[i] <= 1'b0;
      end
      if ((|done_bad) || (order && !sel_onehot)) err <= 1'b1;
    end
  end

  wb_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(WB_DEPTH)
  ) u_wb_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (grant_any),
    .din  (fifo_din),
    .pop  (wb_pop),
    .dout (fifo_dout),
    .valid(wb_valid),
    .full (fifo_full)
  );

  assign {wb_pa, wb_data} = fifo_dout;

endmodule

// File: tb/tb_exec_dispatch.sv
// tb_exec_dispatch
// Self-checking bench for exec_dispatch at default parameters. Expected
// write-back entries are queued when a completion is driven and compared
// when the DUT presents them on the write-back port.
module tb_exec_dispatch;
  import exec_dispatch_pkg::*;

  localparam int N  = 4;
  localparam int LW = 32;
  localparam int LP = 6;
  localparam int WD = 4;
  localparam int W  = LP + LW;

  logic            clk;
  logic            rst;
  logic            order;
  logic [N-1:0]    unit_sel;
  logic            rd_en;
  logic [LP-1:0]   pa_rd_in;
  logic            accepted;
  logic            busy_out;
  logic [N-1:0]    u_order;
  logic [N-1:0]    u_accepted;
  logic [N-1:0]    u_done;
  logic [N*LW-1:0] u_rd;
  logic            wb_valid;
  logic            wb_ready;
  logic [LP-1:0]   wb_pa;
  logic [LW-1:0]   wb_data;
  logic            err;

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;

  exec_dispatch #(
    .N_UNIT  (N),
    .LEN_WORD(LW),
    .LEN_PREG(LP),
    .WB_DEPTH(WD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .order     (order),
    .unit_sel  (unit_sel),
    .rd_en     (rd_en),
    .pa_rd_in  (pa_rd_in),
    .accepted  (accepted),
    .busy_out  (busy_out),
    .u_order   (u_order),
    .u_accepted(u_accepted),
    .u_done    (u_done),
    .u_rd      (u_rd),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_pa     (wb_pa),
    .wb_data   (wb_data),
    .err       (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare every transferred write-back entry with the queue head.
  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) check("wb_extra_entry", W'(0), W'(1));
      else check("wb_entry", {wb_pa, wb_data}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wb(input logic [LP-1:0] pa, input logic [LW-1:0] data);
    exp_q.push_back(pack_wb_entry(pa, data));
  endtask

  task automatic issue(input int u, input logic rd, input logic [LP-1:0] pa);
    order      = 1'b1;
    unit_sel   = '0;
    unit_sel[u] = 1'b1;
    u_accepted = unit_sel;
    rd_en      = rd;
    pa_rd_in   = pa;
    #1;
    check($sformatf("issue_accepted_u%0d", u), W'(accepted), W'(1));
    check($sformatf("issue_busy_u%0d", u), W'(busy_out), W'(0));
    step();
    order      = 1'b0;
    unit_sel   = '0;
    u_accepted = '0;
    rd_en      = 1'b0;
    pa_rd_in   = '0;
  endtask

  // Pulse u_done on every unit in mask; unit i reports base + i.
  task automatic done(input logic [N-1:0] mask, input logic [LW-1:0] base);
    for (int i = 0; i < N; i++)
      if (mask[i]) u_rd[i*LW +: LW] = base + LW'(i);
    u_done = mask;
    step();
    u_done = '0;
    u_rd   = '0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_queue_empty", W'(exp_q.size()), W'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    order      = 1'b0;
    unit_sel   = '0;
    rd_en      = 1'b0;
    pa_rd_in   = '0;
    u_accepted = '0;
    u_done     = '0;
    u_rd       = '0;
    wb_ready   = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_accepted", W'(accepted), W'(0));
    check("rst_u_order",  W'(u_order),  W'(0));
    check("rst_wb_valid", W'(wb_valid), W'(0));
    check("rst_busy_out", W'(busy_out), W'(0));
    check("rst_err",      W'(err),      W'(0));

    // Single op with result: done two cycles after issue, wb two after done
    issue(0, 1'b1, 6'd5);
    step();
    expect_wb(6'd5, 32'h0000_00AA);
    u_done = 4'b0001;
    u_rd   = '0;
    u_rd[0 +: LW] = 32'h0000_00AA;
    #1;
    check("lat_done_cycle", W'(wb_valid), W'(0));
    step();
    u_done = '0;
    u_rd   = '0;
    check("lat_hold_cycle", W'(wb_valid), W'(0));
    step();
    check("lat_wb_valid", W'(wb_valid), W'(1));
    check("lat_wb_pa",    W'(wb_pa),    W'(5));
    check("lat_wb_data",  W'(wb_data),  W'(32'hAA));
    wait_drain(10);

    // Out-of-order completion: unit 0 finishes before unit 2
    issue(2, 1'b1, 6'd7);
    issue(0, 1'b1, 6'd3);
    step();
    expect_wb(6'd3, 32'h30);
    done(4'b0001, 32'h30);
    step();
    expect_wb(6'd7, 32'h70);
    done(4'b0100, 32'h6E);
    wait_drain(10);

    // Prior grant to unit 1, then simultaneous completion on 0, 1, 3
    issue(1, 1'b1, 6'd9);
    expect_wb(6'd9, 32'h101);
    done(4'b0010, 32'h100);
    wait_drain(10);
    issue(0, 1'b1, 6'd20);
    issue(1, 1'b1, 6'd21);
    issue(3, 1'b1, 6'd23);
`ifdef EXEC_DISPATCH_RR_ARB_EN
    expect_wb(6'd23, 32'h203);
    expect_wb(6'd20, 32'h200);
    expect_wb(6'd21, 32'h201);
`else
    expect_wb(6'd20, 32'h200);
    expect_wb(6'd21, 32'h201);
    expect_wb(6'd23, 32'h203);
`endif
    done(4'b1011, 32'h200);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("multi_wb_valid_%0d", k), W'(wb_valid), W'(1));
    end
    step();
    check("multi_wb_idle", W'(wb_valid), W'(0));
    check("multi_queue_empty", W'(exp_q.size()), W'(0));

    // Backpressure: four results fill the FIFO, the fifth waits in hold
    wb_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      issue(k, 1'b1, LP'(10 + k));
      expect_wb(LP'(10 + k), 32'h300 + 32'(k));
      done(4'(1 << k), 32'h300);
      repeat (2) step();
    end
    issue(0, 1'b1, 6'd14);
    expect_wb(6'd14, 32'h304);
    done(4'b0001, 32'h304);
    repeat (3) step();
    check("bp_wb_valid", W'(wb_valid), W'(1));
    check("bp_head", {wb_pa, wb_data}, exp_q[0]);
    order      = 1'b1;
    unit_sel   = 4'b0001;
    u_accepted = 4'b0001;
    rd_en      = 1'b1;
    pa_rd_in   = 6'd15;
    #1;
    check("bp_busy_out", W'(busy_out), W'(1));
    check("bp_accepted", W'(accepted), W'(0));
    check("bp_u_order",  W'(u_order),  W'(0));
    step();
    order      = 1'b0;
    unit_sel   = '0;
    u_accepted = '0;
    rd_en      = 1'b0;
    pa_rd_in   = '0;
    wb_ready   = 1'b1;
    wait_drain(20);

    // rd_en=0 op: no write-back, unit free on the following cycle
    issue(1, 1'b0, 6'd0);
    done(4'b0010, 32'h0);
    issue(1, 1'b0, 6'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("nord_wb_idle_%0d", k), W'(wb_valid), W'(0));
      step();
    end
    done(4'b0010, 32'h0);
    step();
    check("nord_wb_idle_end", W'(wb_valid), W'(0));

    // Spurious done sets sticky err; reset clears all and ignores late done
    issue(3, 1'b1, 6'd33);
    done(4'b0100, 32'h0);
    check("err_set", W'(err), W'(1));
    repeat (2) step();
    check("err_sticky", W'(err), W'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post_rst_err",      W'(err),      W'(0));
    check("post_rst_wb_valid", W'(wb_valid), W'(0));
    for (int u = 0; u < N; u++) begin
      order       = 1'b1;
      unit_sel    = '0;
      unit_sel[u] = 1'b1;
      #1;
      check($sformatf("post_rst_free_u%0d", u), W'(busy_out), W'(0));
    end
    order    = 1'b0;
    unit_sel = '0;
    step();
    done(4'b1000, 32'h55);
    step();
    check("late_done_err",      W'(err),      W'(0));
    check("late_done_wb_valid", W'(wb_valid), W'(0));

    // Random single ops after reset to confirm normal service resumes
    for (int k = 0; k < 6; k++) begin
      int u;
      logic [LW-1:0] base;
      u    = $urandom_range(0, N-1);
      base = LW'($urandom_range(0, 32'hFFFF));
      issue(u, 1'b1, LP'(40 + k));
      repeat ($urandom_range(0, 3)) step();
      expect_wb(LP'(40 + k), base + LW'(u));
      done(4'(1 << u), base);
      wait_drain(10);
    end
    check("final_err", W'(err), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
